// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional build macro used by fetch_stage: FETCH_MISALIGN_TRAP_EN.
package fetch_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] instr_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // sll $0,$0,0 encodes as all zeros
  localparam instr_t NOP_INSTR_C = 32'h0000_0000;
  localparam addr_t  RESET_PC_C  = 32'h0000_0000;

endpackage : fetch_pkg

// File: rtl/fetch_next_pc.sv
// Next-PC selection: jump beats branch, branch beats sequential pc+4.
module fetch_next_pc
  import fetch_pkg::*;
(
  input  addr_t pc_i,
  input  logic  jump_i,
  input  addr_t pc_jump_i,
  input  logic  branch_i,
  input  addr_t pc_branch_i,
  output logic  redirect_o,
  output addr_t target_o,
  output addr_t pc_plus_4_o,
  output addr_t next_pc_o
);

  // Redirect priority and sequential increment (wraps modulo 2^32)
  always_comb begin
    pc_plus_4_o = pc_i + 32'd4;
    redirect_o  = jump_i | branch_i;
    target_o    = jump_i ? pc_jump_i : pc_branch_i;
    next_pc_o   = redirect_o ? target_o : pc_plus_4_o;
  end

endmodule : fetch_next_pc

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, talks req/ready to a variable-latency imem,
// holds a fetched instruction across stalls and drains a request that
// is still outstanding when D redirects.
// Optional build macro: FETCH_MISALIGN_TRAP_EN (adds fetch_misalign_f and
// suppresses fetch from a misaligned PC instead of masking address bits).
module fetch_stage
  import fetch_pkg::*;
#(
  parameter addr_t  RESET_PC  = RESET_PC_C,
  parameter instr_t NOP_INSTR = NOP_INSTR_C
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   stall_f,
  input  logic   pc_src_d,
  input  addr_t  pc_branch_d,
  input  logic   jump_d,
  input  addr_t  pc_jump_d,
  output logic   imem_req,
  output addr_t  imem_addr,
  input  instr_t imem_rdata,
  input  logic   imem_ready,
  output addr_t  pc_f,
  output addr_t  pc_plus_4_f,
  output instr_t instr_f,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic   fetch_misalign_f,
`endif
  output logic   fetch_valid_f
);

  fetch_state_e state_q, state_d;
  addr_t        pc_q, pc_d;
  instr_t       hold_q, hold_d;
  addr_t        tgt_q, tgt_d;

  logic  redirect;
  logic  take_redir;
  logic  trap;
  addr_t redir_target;
  addr_t next_pc;

  fetch_next_pc u_next_pc (
    .pc_i        (pc_q),
    .jump_i      (jump_d),
    .pc_jump_i   (pc_jump_d),
    .branch_i    (pc_src_d),
    .pc_branch_i (pc_branch_d),
    .redirect_o  (redirect),
    .target_o    (redir_target),
    .pc_plus_4_o (pc_plus_4_f),
    .next_pc_o   (next_pc)
  );

  assign pc_f       = pc_q;
  // D re-presents a redirect while stalled, so only act on it when free
  assign take_redir = redirect & ~stall_f;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign trap             = (state_q == FETCH) && (pc_q[1:0] != 2'b00);
  assign fetch_misalign_f = trap;
`else
  assign trap = 1'b0;
`endif

  // State register; reset abandons any in-flight imem transaction
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      hold_q  <= NOP_INSTR;
      tgt_q   <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      hold_q  <= hold_d;
      tgt_q   <= tgt_d;
    end
  end

  // Next-state and handshake/output decode
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    hold_d        = hold_q;
    tgt_d         = tgt_q;
    imem_req      = 1'b0;
    imem_addr     = {pc_q[31:2], 2'b00};
    instr_f       = NOP_INSTR;
    fetch_valid_f = 1'b0;

    unique case (state_q)
      FETCH: begin
        if (trap) begin
          // No request from a misaligned PC; wait for D to steer away
          if (take_redir) pc_d = redir_target;
        end else begin
          imem_req = 1'b1;
          if (imem_ready) begin
            // Wrong-path data on a redirect is still presented; D flushes it
            fetch_valid_f = 1'b1;
            instr_f       = imem_rdata;
            if (stall_f) begin
              hold_d  = imem_rdata;
              state_d = HOLD;
            end else begin
              pc_d = next_pc;
            end
          end else if (take_redir) begin
            // Cannot withdraw the request: remember where to go afterwards
            tgt_d   = redir_target;
            state_d = DRAIN;
          end
        end
      end

      HOLD: begin
        instr_f       = hold_q;
        fetch_valid_f = 1'b1;
        if (!stall_f) begin
          pc_d    = next_pc;
          state_d = FETCH;
        end
      end

      DRAIN: begin
        imem_req = 1'b1;
        if (take_redir) tgt_d = redir_target;
        if (imem_ready) begin
          pc_d    = take_redir ? redir_target : tgt_q;
          state_d = FETCH;
        end
      end

      default: state_d = FETCH;
    endcase
  end

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_f = 1'b0;
  logic        pc_src_d = 1'b0;
  logic [31:0] pc_branch_d = '0;
  logic        jump_d = 1'b0;
  logic [31:0] pc_jump_d = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready = 1'b1;
  logic [31:0] pc_f;
  logic [31:0] pc_plus_4_f;
  logic [31:0] instr_f;
  logic        fetch_valid_f;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misalign_f;
`endif

  int total = 0;
  int bad   = 0;

  // Memory data override used for directed data patterns
  bit          use_ovr = 1'b0;
  logic [31:0] ovr_word = '0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall_f       (stall_f),
    .pc_src_d      (pc_src_d),
    .pc_branch_d   (pc_branch_d),
    .jump_d        (jump_d),
    .pc_jump_d     (pc_jump_d),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_ready    (imem_ready),
    .pc_f          (pc_f),
    .pc_plus_4_f   (pc_plus_4_f),
    .instr_f       (instr_f),
`ifdef FETCH_MISALIGN_TRAP_EN
    .fetch_misalign_f (fetch_misalign_f),
`endif
    .fetch_valid_f (fetch_valid_f)
  );

  // Address-tagged instruction memory contents
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return use_ovr ? ovr_word : ((a ^ 32'hC0DE_0000) | 32'h0000_0001);
  endfunction

  // Data is meaningful only with ready; otherwise drive garbage
  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  // Reference model: PC, optional held instruction, optional pending redirect
  logic [31:0] m_pc;
  logic [31:0] m_held_val;
  logic [31:0] m_target;
  bit          m_held;
  bit          m_pending;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic bit m_misaligned();
`ifdef FETCH_MISALIGN_TRAP_EN
    return (m_pc[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs();
    logic [31:0] e_addr;
    logic        e_req, e_valid, e_mis;
    logic [31:0] e_instr;
    e_addr  = m_pc & 32'hFFFF_FFFC;
    e_mis   = 1'b0;
    if (m_held) begin
      e_req = 1'b0; e_valid = 1'b1; e_instr = m_held_val;
    end else if (m_pending) begin
      e_req = 1'b1; e_valid = 1'b0; e_instr = NOP;
    end else if (m_misaligned()) begin
      e_req = 1'b0; e_valid = 1'b0; e_instr = NOP; e_mis = 1'b1;
    end else begin
      e_req   = 1'b1;
      e_valid = imem_ready;
      e_instr = imem_ready ? mem_word(e_addr) : NOP;
    end
    chk("pc_f", pc_f, m_pc);
    chk("pc_plus_4_f", pc_plus_4_f, m_pc + 32'd4);
    chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
    if (e_req) chk("imem_addr", imem_addr, e_addr);
    chk("fetch_valid_f", {31'b0, fetch_valid_f}, {31'b0, e_valid});
    chk("instr_f", instr_f, e_instr);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("fetch_misalign_f", {31'b0, fetch_misalign_f}, {31'b0, e_mis});
`else
    if (e_mis) chk("misalign_model", 32'd1, 32'd0);
`endif
  endtask

  task automatic model_update();
    bit          redir;
    logic [31:0] tgt;
    redir = !stall_f && (jump_d || pc_src_d);
    tgt   = jump_d ? pc_jump_d : pc_branch_d;
    if (reset) begin
      m_pc = RST_PC; m_held = 1'b0; m_pending = 1'b0; m_held_val = NOP;
    end else if (m_held) begin
      if (!stall_f) begin
        m_held = 1'b0;
        m_pc   = redir ? tgt : m_pc + 32'd4;
      end
    end else if (m_pending) begin
      if (redir) m_target = tgt;
      if (imem_ready) begin
        m_pc      = m_target;
        m_pending = 1'b0;
      end
    end else if (m_misaligned()) begin
      if (redir) m_pc = tgt;
    end else if (imem_ready) begin
      if (stall_f) begin
        m_held     = 1'b1;
        m_held_val = mem_word(m_pc & 32'hFFFF_FFFC);
      end else begin
        m_pc = redir ? tgt : m_pc + 32'd4;
      end
    end else if (redir) begin
      m_pending = 1'b1;
      m_target  = tgt;
    end
  endtask

  // One clock: drive inputs, check at negedge, advance model at posedge
  task automatic cycle(input bit rst_v, input bit st, input bit rdy,
                       input bit jmp, input logic [31:0] pj,
                       input bit src, input logic [31:0] pb);
    reset       = rst_v;
    stall_f     = st;
    imem_ready  = rdy;
    jump_d      = jmp;
    pc_jump_d   = pj;
    pc_src_d    = src;
    pc_branch_d = pb;
    @(negedge clk);
    if (!rst_v) check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic seq(input bit st, input bit rdy);
    cycle(1'b0, st, rdy, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    m_pc = RST_PC; m_held = 0; m_pending = 0; m_held_val = NOP; m_target = RST_PC;

    // Reset, then zero-wait fetch of 0,4,8,12
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("reset_pc", pc_f, RST_PC);
    for (int i = 0; i < 4; i++) seq(1'b0, 1'b1);
    chk("seq_pc_16", pc_f, 32'h10);

    // Two-cycle ready latency at 0x10
    seq(1'b0, 1'b0);
    seq(1'b0, 1'b1);
    chk("after_wait_pc", pc_f, 32'h14);

    // Accept 0x22222222 under stall, hold three cycles, release
    use_ovr = 1'b1; ovr_word = 32'h2222_2222;
    seq(1'b1, 1'b1);
    use_ovr = 1'b0;
    for (int i = 0; i < 3; i++) seq(1'b1, 1'b0);
    chk("hold_instr", instr_f, 32'h2222_2222);
    seq(1'b0, 1'b0);
    chk("release_pc", pc_f, 32'h18);

    // Branch while request to 0x20 is outstanding -> drain
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
    seq(1'b0, 1'b0);
    seq(1'b0, 1'b1);
    chk("drain_redirect_pc", pc_f, 32'h40);

    // Jump beats branch; ignored under stall
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h80, 1'b1, 32'h40);
    chk("jump_priority_pc", pc_f, 32'h80);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 1'b1, 32'h40);
    seq(1'b0, 1'b1);
    chk("stalled_redirect_ignored", pc_f, 32'h84);

    // Reset asserted while draining
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    seq(1'b0, 1'b0);
    chk("reset_mid_drain_pc", pc_f, RST_PC);

    // PC wrap past 0xFFFF_FFFC
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    seq(1'b0, 1'b1);
    seq(1'b0, 1'b1);

    // Misaligned jump target
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h42, 1'b0, 32'h0);
    seq(1'b0, 1'b1);
    seq(1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h60, 1'b0, 32'h0);
    seq(1'b0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t1, t2;
      bit st, rdy, jmp, src;
      st  = ($urandom_range(0, 3) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      jmp = ($urandom_range(0, 9) == 0);
      src = ($urandom_range(0, 7) == 0);
      t1  = $urandom;
      t2  = $urandom;
      if ($urandom_range(0, 7) != 0) t1 = t1 & 32'hFFFF_FFFC;
      if ($urandom_range(0, 7) != 0) t2 = t2 & 32'hFFFF_FFFC;
      cycle(($urandom_range(0, 99) == 0), st, rdy, jmp, t1, src, t2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_stage
